// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types, limits and window test for the dual-port RAM
package ram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } port_state_t;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 4;

   // Wide enough to hold LATENCY_MAX-2, the largest preload of the wait counter
   localparam int CNT_W = 2;

   // True when the bits above the window size match the base address
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          aw);
      logic [31:0] mask;
      mask = ~((32'd1 << aw) - 32'd1);
      return ((addr ^ base) & mask) == 32'd0;
   endfunction

endpackage

// File: rtl/ram_port_ctrl.sv
// rtl/ram_port_ctrl.sv - per-port handshake FSM, latency counter and response pipeline
module ram_port_ctrl
   import ram_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic        is_write,
   input  logic        ok,
   input  logic [31:0] mem_word,
   output logic        accept,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        error
);

   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   port_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rdata_q;
   logic             error_q;

   // State, counter and the response captured at the acceptance edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rdata_q <= (is_write || !ok) ? 32'd0 : mem_word;
            error_q <= !ok;
         end
      end
   end

   // Next state: accept only from IDLE, count down in WAIT, one RESP cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (valid) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign ready = (state_q == ST_RESP);
   assign rdata = ready ? rdata_q : 32'd0;
   assign error = ready & error_q;

endmodule

// File: rtl/ram_dp.sv
// rtl/ram_dp.sv - dual-port byte-writable RAM; RAM_BOUNDS_CHECK_EN enables the window check
module ram_dp
   import ram_pkg::*;
#(
   parameter int          RAM_AW   = 16,
   parameter logic [31:0] RAM_BASE = 32'h8000_0000,
   parameter int          LATENCY  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] p0_address,
   input  logic [31:0] p0_wdata,
   input  logic [3:0]  p0_wsel,
   input  logic        p0_valid,
   output logic [31:0] p0_rdata,
   output logic        p0_ready,
   output logic        p0_error,
   input  logic [31:0] p1_address,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p1_wsel,
   input  logic        p1_valid,
   output logic [31:0] p1_rdata,
   output logic        p1_ready,
   output logic        p1_error
);

   localparam int WORDS = 2 ** (RAM_AW - 2);

   generate
      if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
         $error("ram_dp: LATENCY must be within 1..4");
      end
   endgenerate

   logic [31:0]       mem [WORDS];
   logic [RAM_AW-3:0] idx0, idx1;
   logic              ok0, ok1;
   logic              acc0, acc1;
   logic              we0, we1;
   logic              unused_addr;

   assign idx0 = p0_address[RAM_AW-1:2];
   assign idx1 = p1_address[RAM_AW-1:2];

`ifdef RAM_BOUNDS_CHECK_EN
   assign ok0         = in_window(p0_address, RAM_BASE, RAM_AW);
   assign ok1         = in_window(p1_address, RAM_BASE, RAM_AW);
   assign unused_addr = ^{p0_address[1:0], p1_address[1:0]};
`else
   // Without the check every access aliases into the RAM
   assign ok0         = 1'b1;
   assign ok1         = 1'b1;
   assign unused_addr = ^{p0_address[31:RAM_AW], p0_address[1:0],
                          p1_address[31:RAM_AW], p1_address[1:0], RAM_BASE};
`endif

   ram_port_ctrl #(.LATENCY(LATENCY)) u_port0 (
      .clk      (clk),
      .rst      (rst),
      .valid    (p0_valid),
      .is_write (|p0_wsel),
      .ok       (ok0),
      .mem_word (mem[idx0]),
      .accept   (acc0),
      .ready    (p0_ready),
      .rdata    (p0_rdata),
      .error    (p0_error)
   );

   ram_port_ctrl #(.LATENCY(LATENCY)) u_port1 (
      .clk      (clk),
      .rst      (rst),
      .valid    (p1_valid),
      .is_write (|p1_wsel),
      .ok       (ok1),
      .mem_word (mem[idx1]),
      .accept   (acc1),
      .ready    (p1_ready),
      .rdata    (p1_rdata),
      .error    (p1_error)
   );

   assign we0 = acc0 & (|p0_wsel) & ok0;
   assign we1 = acc1 & (|p1_wsel) & ok1;

   // Lane writes at acceptance; port 1 is issued last so it wins overlapping lanes
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we0 && p0_wsel[b]) mem[idx0][8*b +: 8] <= p0_wdata[8*b +: 8];
         if (we1 && p1_wsel[b]) mem[idx1][8*b +: 8] <= p1_wdata[8*b +: 8];
      end
   end

endmodule
